mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-port controller that shares the single-ported zero-delay RAM between the instruction-fetch stage and the load/store stage of the RISCV32I core. It arbitrates round-robin between the ports and sequences sub-word stores as read-modify-write. It also performs byte/halfword load extraction with sign or zero extension on the big-endian byte array, and flags out-of-range or misaligned accesses. It sits between the core and the RAM; the RAM's address, data-in, write-control and read-data pins connect only to this block.

## Interface
- `dataW`, 32: data width; the only supported value is 32.
- `RAMAddrSize`, 16: RAM byte-address width; it must match the RAM instance.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `ifReq` in 1: fetch request (level).
- `ifAddr` in RAMAddrSize: fetch byte address.
- `ifGnt` out 1: combinational; the fetch is accepted this cycle.
- `ifValid` out 1: registered one-cycle pulse; `ifRData`/`ifErr` are valid.
- `ifRData` out 32: fetched word.
- `ifErr` out 1: misaligned or out-of-range fetch.
- `dReq` in 1: data request (level).
- `dWrite` in 1: 1 = store, 0 = load.
- `dSize` in 2: 00 byte, 01 half, 10 word; 11 is illegal.
- `dUnsigned` in 1: zero-extend loads.
- `dAddr` in RAMAddrSize: data byte address.
- `dWData` in 32: store data, right-justified.
- `dGnt` out 1: combinational accept.
- `dValid` out 1: registered completion pulse.
- `dRData` out 32: extended load data; 0 for stores.
- `dErr` out 1: access rejected; no RAM write occurred.
- `RAMAddr` out RAMAddrSize: RAM address.
- `RAMDataIn` out 32: RAM write data.
- `RAMWriteControl` out 1: RAM write strobe.
- `RAMOut` in 32: RAM read data (combinational).

## Operation
- FSM states:
  - IDLE: may grant.
  - RMW_WR: second cycle of a sub-word store; no grants.
- Arbitration in IDLE:
  - Requests from only one port are granted immediately.
  - When both ports request, the port not granted last wins. The `lastGnt` bit resets to fetch, so data wins the first tie.
  - The requester may change its request fields after the granting edge.
- Fetch: in the grant cycle `RAMAddr=ifAddr`; `RAMOut` is captured into `ifRData`.
- Word store: written in the grant cycle (`RAMWriteControl=1`, `RAMDataIn=dWData`).
- Sub-word store:
  - Grant cycle: read the old word and register merge data and address; go to RMW_WR.
  - RMW_WR: write the merged word.
    - Byte store: {dWData[7:0], old[23:0]}.
    - Half store: {dWData[15:0], old[15:0]}.
  - Return to IDLE.
- Loads, big-endian (byte at `dAddr` is `RAMOut[31:24]`):
  - Byte load: `RAMOut[31:24]`, extended to 32 bits.
  - Half load: `RAMOut[31:16]`, extended to 32 bits.
  - Word load: `RAMOut`.
  - Misaligned data addresses are legal.
- Errors are detected at grant. An errored access performs no RAM write, and the response carries `*Err=1` with data 0.
  - Range: the access last byte `addr+size-1` exceeds 2^RAMAddrSize−1 (no wrap-around).
  - Fetch: `ifAddr[1:0]!=0`.
  - Data: `dSize=11`.
  - An errored sub-word store does not enter RMW_WR.
- `RAMWriteControl` is 0 whenever no store write cycle is active. `RAMAddr` holds its last value when idle.

## Timing
- Reset values:
  - State: IDLE.
  - `lastGnt`: fetch.
  - Outputs 0: `ifValid`, `dValid`, `ifErr`, `dErr`, `ifRData`, `dRData`, and the merge registers.
- Reset mid-RMW abandons the write. No write strobe may be issued after reset asserts.
- Latency from grant edge to valid:
  - Load, fetch, word store: 1 cycle.
  - Sub-word store: 2 cycles.
- Throughput:
  - One access per cycle in IDLE.
  - A sub-word store blocks both ports for one extra cycle; `ifGnt`/`dGnt` are 0 in RMW_WR.
- Both grants are never high in the same cycle. At most one valid pulses per cycle.
- Fetch is not blocked by a pending data valid; a grant may coincide with the previous valid.

## Structure
- `mem_ctrl_pkg` holds:
  - The `mem_size_e` enum (BYTE, HALF, WORD, ILLEGAL).
  - The `arb_state_e` enum (IDLE, RMW_WR).
  - A `size_bytes()` function.
- One combinational sub-module, `mem_lane_align`. It performs load extraction/extension and store merge from (size, unsigned, RAM word, write data).

## Test plan
- Reset, then fetch at 0x0004 with RAM[4..7]=01 02 03 04: `ifGnt` same cycle, then `ifValid` with `ifRData=0x01020304`, `ifErr=0`.
- Both ports request every cycle:
  - Grants alternate data, fetch, data, …, starting with data.
  - Each grant is followed by exactly one valid on the correct port.
- Store byte 0xAB at 0x0101 over word 0x11223344:
  - Two RAM cycles; `dValid` two cycles after grant.
  - Load word 0x0101 returns 0xAB223344.
  - Fetch requested during RMW_WR is not granted until the cycle after.
- With RAM[0x10]=0x80, 0x7F:
  - Signed byte load at 0x10: 0xFFFFFF80.
  - Unsigned byte load: 0x00000080.
  - Signed half load: 0xFFFF807F.
- Errors:
  - Word store at 0xFFFE (RAMAddrSize=16): `dErr=1`, no write strobe.
  - Fetch at 0x0002: `ifErr=1`.
  - `dSize=11`: `dErr=1`.
- Reset asserted during RMW_WR: `RAMWriteControl` never pulses and the target word is unchanged. After release, state is IDLE and a data request wins the first tie.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types for the instruction/data memory port arbiter.
//   mem_size_e  : access size encoding carried on dSize
//   arb_state_e : arbiter FSM states
//   port_e      : which port received the most recent grant
//   size_bytes(): number of bytes touched by an access of a given size
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        BYTE    = 2'b00,
        HALF    = 2'b01,
        WORD    = 2'b10,
        ILLEGAL = 2'b11
    } mem_size_e;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } arb_state_e;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } port_e;

    // ILLEGAL is rejected separately; give it a full word so the range
    // check stays conservative.
    function automatic logic [2:0] size_bytes(input mem_size_e sz);
        case (sz)
            BYTE:    return 3'd1;
            HALF:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane alignment for the big-endian RAM word.
// The addressed byte is always ram_word_i[31:24].
//   size_i       : access size
//   unsigned_i   : zero-extend (1) or sign-extend (0) sub-word loads
//   ram_word_i   : word read from the RAM at the access address
//   wdata_i      : right-justified store data
//   load_data_o  : extracted and extended load result
//   merge_data_o : word to write back for a store
module mem_lane_align
    import mem_ctrl_pkg::*;
#(
    parameter int dataW = 32
) (
    input  mem_size_e        size_i,
    input  logic             unsigned_i,
    input  logic [dataW-1:0] ram_word_i,
    input  logic [dataW-1:0] wdata_i,
    output logic [dataW-1:0] load_data_o,
    output logic [dataW-1:0] merge_data_o
);

    logic sext;
    assign sext = ~unsigned_i & ram_word_i[31];

    always_comb begin
        case (size_i)
            BYTE:    load_data_o = {{24{sext}}, ram_word_i[31:24]};
            HALF:    load_data_o = {{16{sext}}, ram_word_i[31:16]};
            default: load_data_o = ram_word_i;
        endcase
    end

    // New bytes land in the leading (lowest-address) lanes; the rest of
    // the old word is written back unchanged.
    always_comb begin
        case (size_i)
            BYTE:    merge_data_o = {wdata_i[7:0],  ram_word_i[23:0]};
            HALF:    merge_data_o = {wdata_i[15:0], ram_word_i[15:0]};
            default: merge_data_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one zero-delay single-ported RAM between instruction fetch and
// load/store. Round-robin on ties, sub-word stores as read-modify-write,
// big-endian load extraction, range/alignment/size error detection.
//   clock, reset            : clock, async active-low reset
//   ifReq/ifAddr            : fetch request; ifGnt accepts combinationally
//   ifValid/ifRData/ifErr   : registered fetch response
//   dReq/dWrite/dSize/dUnsigned/dAddr/dWData : data request; dGnt accepts
//   dValid/dRData/dErr      : registered data response
//   RAMAddr/RAMDataIn/RAMWriteControl/RAMOut : RAM pins
module mem_port_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int dataW       = 32,
    parameter int RAMAddrSize = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   ifReq,
    input  logic [RAMAddrSize-1:0] ifAddr,
    output logic                   ifGnt,
    output logic                   ifValid,
    output logic [dataW-1:0]       ifRData,
    output logic                   ifErr,
    input  logic                   dReq,
    input  logic                   dWrite,
    input  logic [1:0]             dSize,
    input  logic                   dUnsigned,
    input  logic [RAMAddrSize-1:0] dAddr,
    input  logic [dataW-1:0]       dWData,
    output logic                   dGnt,
    output logic                   dValid,
    output logic [dataW-1:0]       dRData,
    output logic                   dErr,
    output logic [RAMAddrSize-1:0] RAMAddr,
    output logic [dataW-1:0]       RAMDataIn,
    output logic                   RAMWriteControl,
    input  logic [dataW-1:0]       RAMOut
);

    arb_state_e             state_q, state_d;
    port_e                  lastGnt_q, lastGnt_d;
    logic [RAMAddrSize-1:0] addr_q, addr_d;
    logic [dataW-1:0]       merge_q, merge_d;
    logic                   ifValid_q, ifValid_d, ifErr_q, ifErr_d;
    logic [dataW-1:0]       ifRData_q, ifRData_d;
    logic                   dValid_q, dValid_d, dErr_q, dErr_d;
    logic [dataW-1:0]       dRData_q, dRData_d;

    mem_size_e            dSizeE;
    logic [RAMAddrSize:0] ifLast, dLast;
    logic                 ifErrNow, dErrNow, subWord, startRmw;
    logic [dataW-1:0]     loadData, mergeData;

    assign dSizeE = mem_size_e'(dSize);

    // Last byte address with one extra bit: a carry out means the access
    // runs past the top of the RAM (no wrap-around).
    assign ifLast   = {1'b0, ifAddr} + (RAMAddrSize+1)'(3'd3);
    assign dLast    = {1'b0, dAddr} + (RAMAddrSize+1)'(size_bytes(dSizeE) - 3'd1);
    assign ifErrNow = (|ifAddr[1:0]) | ifLast[RAMAddrSize];
    assign dErrNow  = (dSizeE == ILLEGAL) | dLast[RAMAddrSize];
    assign subWord  = (dSizeE == BYTE) | (dSizeE == HALF);
    assign startRmw = dGnt & dWrite & subWord & ~dErrNow;

    mem_lane_align #(.dataW(dataW)) u_align (
        .size_i       (dSizeE),
        .unsigned_i   (dUnsigned),
        .ram_word_i   (RAMOut),
        .wdata_i      (dWData),
        .load_data_o  (loadData),
        .merge_data_o (mergeData)
    );

    // FSM: state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (startRmw) state_d = RMW_WR;
            RMW_WR:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs. Grants are gated by reset so nothing, in particular a
    // word-store strobe, can be issued while reset is held.
    always_comb begin
        ifGnt           = 1'b0;
        dGnt            = 1'b0;
        RAMAddr         = addr_q;
        RAMDataIn       = dWData;
        RAMWriteControl = 1'b0;
        if (state_q == RMW_WR) begin
            RAMDataIn       = merge_q;
            RAMWriteControl = reset;
        end else if (reset) begin
            if (ifReq && dReq) begin
                dGnt  = (lastGnt_q == GNT_FETCH);
                ifGnt = (lastGnt_q == GNT_DATA);
            end else begin
                ifGnt = ifReq;
                dGnt  = dReq;
            end
            if (ifGnt) begin
                RAMAddr = ifAddr;
            end else if (dGnt) begin
                RAMAddr         = dAddr;
                RAMWriteControl = dWrite & (dSizeE == WORD) & ~dErrNow;
            end
        end
    end

    // Response and merge datapath
    always_comb begin
        lastGnt_d = lastGnt_q;
        addr_d    = addr_q;
        merge_d   = merge_q;
        ifValid_d = 1'b0;
        ifErr_d   = ifErr_q;
        ifRData_d = ifRData_q;
        dValid_d  = 1'b0;
        dErr_d    = dErr_q;
        dRData_d  = dRData_q;
        if (ifGnt) begin
            lastGnt_d = GNT_FETCH;
            addr_d    = ifAddr;
            ifValid_d = 1'b1;
            ifErr_d   = ifErrNow;
            ifRData_d = ifErrNow ? '0 : RAMOut;
        end
        if (dGnt) begin
            lastGnt_d = GNT_DATA;
            addr_d    = dAddr;
            if (startRmw) begin
                merge_d = mergeData;   // response comes from RMW_WR
            end else begin
                dValid_d = 1'b1;
                dErr_d   = dErrNow;
                dRData_d = (dErrNow || dWrite) ? '0 : loadData;
            end
        end
        if (state_q == RMW_WR) begin
            dValid_d = 1'b1;
            dErr_d   = 1'b0;
            dRData_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lastGnt_q <= GNT_FETCH;
            addr_q    <= '0;
            merge_q   <= '0;
            ifValid_q <= 1'b0;
            ifErr_q   <= 1'b0;
            ifRData_q <= '0;
            dValid_q  <= 1'b0;
            dErr_q    <= 1'b0;
            dRData_q  <= '0;
        end else begin
            lastGnt_q <= lastGnt_d;
            addr_q    <= addr_d;
            merge_q   <= merge_d;
            ifValid_q <= ifValid_d;
            ifErr_q   <= ifErr_d;
            ifRData_q <= ifRData_d;
            dValid_q  <= dValid_d;
            dErr_q    <= dErr_d;
            dRData_q  <= dRData_d;
        end
    end

    assign ifValid = ifValid_q;
    assign ifErr   = ifErr_q;
    assign ifRData = ifRData_q;
    assign dValid  = dValid_q;
    assign dErr    = dErr_q;
    assign dRData  = dRData_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: RAM model, directed vector table, hand-written
// multi-cycle sequences, then random traffic against a byte-level model.
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        ifReq, ifGnt, ifValid, ifErr;
    logic [15:0] ifAddr;
    logic [31:0] ifRData;
    logic        dReq, dWrite, dUnsigned, dGnt, dValid, dErr;
    logic [1:0]  dSize;
    logic [15:0] dAddr;
    logic [31:0] dWData, dRData;
    logic [15:0] RAMAddr;
    logic [31:0] RAMDataIn, RAMOut;
    logic        RAMWriteControl;

    mem_port_arbiter #(.dataW(32), .RAMAddrSize(16)) dut (
        .clock(clock), .reset(reset),
        .ifReq(ifReq), .ifAddr(ifAddr), .ifGnt(ifGnt), .ifValid(ifValid),
        .ifRData(ifRData), .ifErr(ifErr),
        .dReq(dReq), .dWrite(dWrite), .dSize(dSize), .dUnsigned(dUnsigned),
        .dAddr(dAddr), .dWData(dWData), .dGnt(dGnt), .dValid(dValid),
        .dRData(dRData), .dErr(dErr),
        .RAMAddr(RAMAddr), .RAMDataIn(RAMDataIn),
        .RAMWriteControl(RAMWriteControl), .RAMOut(RAMOut)
    );

    always #5 clock = ~clock;

    // ---------------- RAM model (big-endian, bytes past 0xFFFF absent) -----
    bit [7:0]    mem [65536];
    bit [7:0]    shadow [65536];
    logic        pl_en = 1'b0;
    logic [15:0] pl_addr = '0;
    logic [7:0]  pl_byte = '0;
    int          wr_cnt = 0;

    assign RAMOut[31:24] = mem[RAMAddr];
    assign RAMOut[23:16] = (RAMAddr <= 16'hFFFE) ? mem[RAMAddr + 16'd1] : 8'h00;
    assign RAMOut[15:8]  = (RAMAddr <= 16'hFFFD) ? mem[RAMAddr + 16'd2] : 8'h00;
    assign RAMOut[7:0]   = (RAMAddr <= 16'hFFFC) ? mem[RAMAddr + 16'd3] : 8'h00;

    always @(posedge clock) begin
        if (RAMWriteControl) begin
            wr_cnt <= wr_cnt + 1;
            for (int k = 0; k < 4; k++)
                if (32'(RAMAddr) + k <= 65535)
                    mem[16'(32'(RAMAddr) + k)] <= RAMDataIn[31-8*k -: 8];
        end
        if (pl_en) mem[pl_addr] <= pl_byte;
    end

    // ---------------- checking ----------------
    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic poke_word(input logic [15:0] a, input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            pl_en = 1'b1; pl_addr = a + 16'(k); pl_byte = w[31-8*k -: 8];
            @(posedge clock); #1;
        end
        pl_en = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          fetch;
        bit          wr;
        logic [1:0]  size;
        bit          uns;
        logic [15:0] addr;
        logic [31:0] wdata;
        bit          exp_err;
        logic [31:0] exp_data;
        int          exp_lat;
        int          exp_wr;
    } vec_t;
    vec_t vecs[17];

    function automatic vec_t mkv(bit f, bit w, logic [1:0] s, bit u, logic [15:0] a,
                                 logic [31:0] wd, bit e, logic [31:0] d, int l, int nw);
        vec_t v;
        v.fetch = f; v.wr = w; v.size = s; v.uns = u; v.addr = a; v.wdata = wd;
        v.exp_err = e; v.exp_data = d; v.exp_lat = l; v.exp_wr = nw;
        return v;
    endfunction

    task automatic do_access(input vec_t v, input int idx);
        int  wr0, lat;
        bit  got;
        logic e;
        logic [31:0] d;
        @(posedge clock); #1;
        wr0 = wr_cnt;
        if (v.fetch) begin
            ifReq = 1'b1; ifAddr = v.addr;
        end else begin
            dReq = 1'b1; dWrite = v.wr; dSize = v.size; dUnsigned = v.uns;
            dAddr = v.addr; dWData = v.wdata;
        end
        @(negedge clock);
        chk($sformatf("vec%0d grant", idx), 32'(v.fetch ? ifGnt : dGnt), 32'd1);
        @(posedge clock); #1;
        ifReq = 1'b0; dReq = 1'b0;
        got = 0; lat = 0; e = 1'bx; d = 'x;
        for (int c = 1; c <= 4 && !got; c++) begin
            @(negedge clock);
            if (v.fetch ? ifValid : dValid) begin
                got = 1; lat = c;
                e = v.fetch ? ifErr : dErr;
                d = v.fetch ? ifRData : dRData;
            end
        end
        chk($sformatf("vec%0d latency", idx), 32'(lat), 32'(v.exp_lat));
        chk($sformatf("vec%0d err", idx), 32'(e), 32'(v.exp_err));
        chk($sformatf("vec%0d data", idx), d, v.exp_data);
        chk($sformatf("vec%0d write strobes", idx), 32'(wr_cnt - wr0), 32'(v.exp_wr));
    endtask

    // ---------------- reference model for random traffic ----------------
    function automatic logic [7:0] sb(input int a);
        return (a <= 65535) ? shadow[a[15:0]] : 8'h00;
    endfunction

    function automatic logic [31:0] sword(input int a);
        return {sb(a), sb(a+1), sb(a+2), sb(a+3)};
    endfunction

    bit          eif_v[4], eif_e[4], ed_v[4], ed_e[4];
    logic [31:0] eif_d[4], ed_d[4];

    initial begin
        bit          prev_d, exp_d, model_last, eg_if, eg_d, err;
        int          wr0, busy_cyc, cyc, nb, s, r;
        logic [31:0] v, w;

        reset = 1'b0;
        ifReq = 0; ifAddr = '0; dReq = 0; dWrite = 0; dSize = '0; dUnsigned = 0;
        dAddr = '0; dWData = '0;

        // Preload while reset is held.
        @(posedge clock); #1;
        poke_word(16'h0004, 32'h01020304);
        poke_word(16'h0101, 32'h11223344);
        poke_word(16'h0010, 32'h807F0000);
        poke_word(16'h0200, 32'hAABBCCDD);
        poke_word(16'hFFFC, 32'h0000005A);
        poke_word(16'h0300, 32'h55667788);
        poke_word(16'h0310, 32'h99AABBCC);

        @(negedge clock);
        chk("reset ifValid", 32'(ifValid), 0);
        chk("reset dValid", 32'(dValid), 0);
        chk("reset ifErr", 32'(ifErr), 0);
        chk("reset dErr", 32'(dErr), 0);
        chk("reset ifRData", ifRData, 0);
        chk("reset dRData", dRData, 0);
        chk("reset strobe", 32'(RAMWriteControl), 0);
        @(posedge clock); #1;
        reset = 1'b1;

        // Both ports request every cycle: data, fetch, data, ...
        ifReq = 1; ifAddr = 16'h0004; dReq = 1; dWrite = 0; dSize = 2'b10; dAddr = 16'h0010;
        prev_d = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            exp_d = (i % 2 == 0);
            chk($sformatf("tie%0d dGnt", i), 32'(dGnt), 32'(exp_d));
            chk($sformatf("tie%0d ifGnt", i), 32'(ifGnt), 32'(!exp_d));
            if (i > 0) begin
                chk($sformatf("tie%0d dValid", i), 32'(dValid), 32'(prev_d));
                chk($sformatf("tie%0d ifValid", i), 32'(ifValid), 32'(!prev_d));
            end
            prev_d = exp_d;
        end
        @(posedge clock); #1;
        ifReq = 0; dReq = 0;
        @(negedge clock);
        chk("tie last dValid", 32'(dValid), 32'(prev_d));
        chk("tie last ifValid", 32'(ifValid), 32'(!prev_d));

        // Directed table: {fetch, wr, size, uns, addr, wdata, err, data, latency, strobes}
        vecs[0]  = mkv(1, 0, 2'b10, 0, 16'h0004, 32'h0, 0, 32'h01020304, 1, 0);
        vecs[1]  = mkv(0, 1, 2'b00, 0, 16'h0101, 32'h000000AB, 0, 32'h0, 2, 1);
        vecs[2]  = mkv(0, 0, 2'b10, 0, 16'h0101, 32'h0, 0, 32'hAB223344, 1, 0);
        vecs[3]  = mkv(0, 0, 2'b00, 0, 16'h0010, 32'h0, 0, 32'hFFFFFF80, 1, 0);
        vecs[4]  = mkv(0, 0, 2'b00, 1, 16'h0010, 32'h0, 0, 32'h00000080, 1, 0);
        vecs[5]  = mkv(0, 0, 2'b01, 0, 16'h0010, 32'h0, 0, 32'hFFFF807F, 1, 0);
        vecs[6]  = mkv(0, 0, 2'b01, 1, 16'h0010, 32'h0, 0, 32'h0000807F, 1, 0);
        vecs[7]  = mkv(0, 1, 2'b10, 0, 16'hFFFE, 32'hDEADBEEF, 1, 32'h0, 1, 0);
        vecs[8]  = mkv(1, 0, 2'b10, 0, 16'h0002, 32'h0, 1, 32'h0, 1, 0);
        vecs[9]  = mkv(0, 0, 2'b11, 0, 16'h0020, 32'h0, 1, 32'h0, 1, 0);
        vecs[10] = mkv(0, 1, 2'b01, 0, 16'h0200, 32'h1234BEEF, 0, 32'h0, 2, 1);
        vecs[11] = mkv(0, 0, 2'b10, 0, 16'h0200, 32'h0, 0, 32'hBEEFCCDD, 1, 0);
        vecs[12] = mkv(0, 0, 2'b00, 1, 16'hFFFF, 32'h0, 0, 32'h0000005A, 1, 0);
        vecs[13] = mkv(0, 0, 2'b01, 1, 16'hFFFF, 32'h0, 1, 32'h0, 1, 0);
        vecs[14] = mkv(0, 1, 2'b10, 0, 16'h0040, 32'h12345678, 0, 32'h0, 1, 1);
        vecs[15] = mkv(0, 0, 2'b10, 0, 16'h0040, 32'h0, 0, 32'h12345678, 1, 0);
        vecs[16] = mkv(1, 0, 2'b10, 0, 16'hFFFC, 32'h0, 0, 32'h0000005A, 1, 0);
        for (int i = 0; i < 17; i++) do_access(vecs[i], i);

        // Fetch requested during RMW_WR waits one cycle.
        @(posedge clock); #1;
        dReq = 1; dWrite = 1; dSize = 2'b00; dAddr = 16'h0300; dWData = 32'h000000C3;
        @(negedge clock);
        chk("rmw dGnt", 32'(dGnt), 1);
        @(posedge clock); #1;
        dReq = 0; ifReq = 1; ifAddr = 16'h0004;
        @(negedge clock);
        chk("rmw ifGnt blocked", 32'(ifGnt), 0);
        chk("rmw strobe", 32'(RAMWriteControl), 1);
        chk("rmw early dValid", 32'(dValid), 0);
        @(negedge clock);
        chk("rmw ifGnt after", 32'(ifGnt), 1);
        chk("rmw dValid", 32'(dValid), 1);
        @(posedge clock); #1;
        ifReq = 0;
        @(negedge clock);
        chk("rmw ifValid", 32'(ifValid), 1);
        chk("rmw ifRData", ifRData, 32'h01020304);
        chk("rmw mem", {mem[16'h300], mem[16'h301], mem[16'h302], mem[16'h303]}, 32'hC3667788);

        // Reset in RMW_WR abandons the write.
        @(posedge clock); #1;
        dReq = 1; dWrite = 1; dSize = 2'b00; dAddr = 16'h0310; dWData = 32'h00000011;
        @(negedge clock);
        chk("rstrmw dGnt", 32'(dGnt), 1);
        @(posedge clock); #1;
        dReq = 0; wr0 = wr_cnt; reset = 1'b0;
        @(negedge clock);
        chk("rstrmw strobe", 32'(RAMWriteControl), 0);
        repeat (2) @(negedge clock);
        @(posedge clock); #1;
        reset = 1'b1;
        chk("rstrmw strobes", 32'(wr_cnt - wr0), 0);
        chk("rstrmw mem", {mem[16'h310], mem[16'h311], mem[16'h312], mem[16'h313]}, 32'h99AABBCC);
        ifReq = 1; ifAddr = 16'h0004; dReq = 1; dWrite = 0; dSize = 2'b10; dAddr = 16'h0010;
        @(negedge clock);
        chk("rstrmw dGnt tie", 32'(dGnt), 1);
        chk("rstrmw ifGnt tie", 32'(ifGnt), 0);
        chk("rstrmw no dValid", 32'(dValid), 0);
        @(posedge clock); #1;
        ifReq = 0; dReq = 0;

        // Random traffic against the byte-level model.
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1; reset = 1'b1;
        shadow = mem;
        model_last = 0; busy_cyc = -1; cyc = 0;
        for (int i = 0; i < 4; i++) begin eif_v[i] = 0; ed_v[i] = 0; end
        for (int it = 0; it < 800; it++) begin
            @(posedge clock); #1;
            if (it < 797) begin
                ifReq = ($urandom_range(0, 3) != 0);
                r = $urandom_range(0, 9);
                if (r < 7)       ifAddr = 16'h0100 + 16'($urandom_range(0, 7) * 4);
                else if (r == 7) ifAddr = 16'h0100 + 16'($urandom_range(0, 31));
                else             ifAddr = 16'hFFF0 + 16'($urandom_range(0, 15));
                dReq = ($urandom_range(0, 3) != 0);
                dWrite = 1'($urandom_range(0, 1));
                r = $urandom_range(0, 15);
                dSize = (r == 0) ? 2'b11 : 2'(r % 3);
                dUnsigned = 1'($urandom_range(0, 1));
                dAddr = ($urandom_range(0, 9) < 8) ? 16'h0100 + 16'($urandom_range(0, 31))
                                                    : 16'hFFF8 + 16'($urandom_range(0, 7));
                dWData = $urandom;
            end else begin
                ifReq = 0; dReq = 0;
            end
            @(negedge clock);
            s = cyc % 4;
            chk("rnd ifValid", 32'(ifValid), 32'(eif_v[s]));
            chk("rnd dValid", 32'(dValid), 32'(ed_v[s]));
            if (eif_v[s]) begin
                chk("rnd ifErr", 32'(ifErr), 32'(eif_e[s]));
                chk("rnd ifRData", ifRData, eif_d[s]);
            end
            if (ed_v[s]) begin
                chk("rnd dErr", 32'(dErr), 32'(ed_e[s]));
                chk("rnd dRData", dRData, ed_d[s]);
            end
            eif_v[s] = 0; ed_v[s] = 0;

            if (busy_cyc == cyc)     begin eg_if = 0; eg_d = 0; end
            else if (ifReq && dReq)  begin eg_d = !model_last; eg_if = model_last; end
            else                     begin eg_if = ifReq; eg_d = dReq; end
            chk("rnd ifGnt", 32'(ifGnt), 32'(eg_if));
            chk("rnd dGnt", 32'(dGnt), 32'(eg_d));

            if (eg_if) begin
                model_last = 0;
                err = (ifAddr[1:0] != 0) || (int'(ifAddr) + 3 > 65535);
                s = (cyc + 1) % 4;
                eif_v[s] = 1; eif_e[s] = err;
                eif_d[s] = err ? 32'h0 : sword(int'(ifAddr));
            end
            if (eg_d) begin
                model_last = 1;
                nb = (dSize == 2'b00) ? 1 : (dSize == 2'b01) ? 2 : 4;
                err = (dSize == 2'b11) || (int'(dAddr) + nb - 1 > 65535);
                v = 32'h0;
                if (!err && !dWrite) begin
                    w = sword(int'(dAddr));
                    v = w >> (8 * (4 - nb));
                    if (nb < 4 && !dUnsigned && v[8*nb-1])
                        v = v | (32'hFFFFFFFF << (8 * nb));
                end else if (!err) begin
                    for (int k = 0; k < nb; k++)
                        shadow[16'(int'(dAddr) + k)] = dWData[8*(nb-1-k) +: 8];
                end
                if (!err && dWrite && nb < 4) begin
                    busy_cyc = cyc + 1;
                    s = (cyc + 2) % 4;
                end else begin
                    s = (cyc + 1) % 4;
                end
                ed_v[s] = 1; ed_e[s] = err; ed_d[s] = v;
            end
            cyc++;
        end

        for (int a = 16'h0100; a < 16'h0124; a++)
            chk($sformatf("final mem[%h]", a), 32'(mem[a]), 32'(shadow[a]));
        for (int a = 16'hFFF0; a <= 16'hFFFF; a++)
            chk($sformatf("final mem[%h]", a), 32'(mem[a]), 32'(shadow[a]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
